// File: rtl/hazard_controller.sv
// hazard_controller: pipeline sequencing for the 5-stage MIPS core.
// Drives PC write enable and the IF/ID / ID/EX hold, flush and bubble
// controls. Hazards are resolved with fixed priority:
// reset > mem_busy > branch/jump > load-use.
// Optional build macro HAZARD_STATS_EN adds saturating stall/flush counters;
// without it stall_count and flush_count read 0.
module hazard_controller #(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        stall_all,
    output logic [1:0]  state,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    // Flush length must fit the 3-bit down-counter and be at least one cycle.
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_cfg
        $error("hazard_controller: FLUSH_CYCLES=%0d outside 1..7", FLUSH_CYCLES);
    end

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MEMWAIT = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    // Counter value loaded on the branch cycle: that cycle is the first flush.
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;
    logic       load_use;
    logic       redirect;

    assign load_use = idex_memread && (idex_rt != 5'd0) &&
                      ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
    assign redirect = branch_taken || jump;
    assign state    = state_reg;

    // Next-state and combinational control outputs from current state and inputs.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        pc_write    = 1'b1;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stall_all   = 1'b0;
        if (reset) begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
            state_next = RUN;
            cnt_next   = 3'd0;
        end else begin
            case (state_reg)
                RUN, LDSTALL: begin
                    if (mem_busy) begin
                        stall_all  = 1'b1;
                        pc_write   = 1'b0;
                        state_next = MEMWAIT;
                    end else if (redirect) begin
                        ifid_flush = 1'b1;
                        if (FLUSH_CYCLES == 1) begin
                            state_next = RUN;
                        end else begin
                            state_next = FLUSH;
                            cnt_next   = FLUSH_INIT;
                        end
                    end else if (load_use && (state_reg == RUN)) begin
                        // The stalled instruction re-enters ID next cycle with
                        // the load result forwardable, so detection is masked.
                        pc_write    = 1'b0;
                        ifid_hold   = 1'b1;
                        idex_bubble = 1'b1;
                        state_next  = LDSTALL;
                    end else begin
                        state_next = RUN;
                    end
                end
                MEMWAIT: begin
                    if (mem_busy) begin
                        stall_all = 1'b1;
                        pc_write  = 1'b0;
                    end else begin
                        state_next = RUN;
                    end
                end
                FLUSH: begin
                    if (mem_busy) begin
                        // Freeze: the flush count resumes once memory is ready.
                        stall_all = 1'b1;
                        pc_write  = 1'b0;
                    end else begin
                        ifid_flush = 1'b1;
                        cnt_next   = cnt_reg - 3'd1;
                        if (cnt_reg == 3'd1) begin
                            state_next = RUN;
                        end
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    // State and flush-counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= RUN;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [1:0] count_en;
    assign count_en = {ifid_flush, ~pc_write};

    // Index 0 counts stall cycles, index 1 counts flush cycles; both saturate.
    for (genvar gi = 0; gi < 2; gi++) begin : g_count
        logic [15:0] count_reg;
        // Saturating event counter, cleared by reset.
        always_ff @(posedge clock) begin
            if (reset) begin
                count_reg <= 16'd0;
            end else if (count_en[gi] && (count_reg != 16'hFFFF)) begin
                count_reg <= count_reg + 16'd1;
            end
        end
    end

    assign stall_count = g_count[0].count_reg;
    assign flush_count = g_count[1].count_reg;
`else
    assign stall_count = 16'd0;
    assign flush_count = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Testbench for hazard_controller: table of per-cycle vectors checked through
// a scoreboard queue, plus hand sequences for FLUSH_CYCLES=1 and counters.
module tb_hazard_controller;

    localparam int FLC = 3;

    // Expected control word: {pc_write, ifid_hold, ifid_flush, idex_bubble, stall_all}
    localparam logic [4:0] NORM = 5'b10000;
    localparam logic [4:0] RSTO = 5'b00100;
    localparam logic [4:0] LU   = 5'b01010;
    localparam logic [4:0] FL   = 5'b10100;
    localparam logic [4:0] ST   = 5'b00001;

    typedef struct {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       memread;
        logic [4:0] ex_rt;
        logic       br;
        logic       jmp;
        logic       busy;
        logic [4:0] ctl;
        logic [1:0] st;
    } vec_t;

    typedef struct {
        int         idx;
        logic [4:0] ctl;
        logic [1:0] st;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, idex_rt;
    logic        id_uses_rt, idex_memread, branch_taken, jump, mem_busy;
    logic        pc_write, ifid_hold, ifid_flush, idex_bubble, stall_all;
    logic [1:0]  state;
    logic [15:0] stall_count, flush_count;
    logic        pc_write1, ifid_hold1, ifid_flush1, idex_bubble1, stall_all1;
    logic [1:0]  state1;
    logic [15:0] stall_count1, flush_count1;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];
    exp_t sb[$];
    int exp_stall = 0;
    int exp_flush = 0;

    always #5 clock = ~clock;

    hazard_controller #(.FLUSH_CYCLES(FLC)) dut (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .idex_memread(idex_memread), .idex_rt(idex_rt),
        .branch_taken(branch_taken), .jump(jump), .mem_busy(mem_busy),
        .pc_write(pc_write), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .stall_all(stall_all), .state(state),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_controller #(.FLUSH_CYCLES(1)) dut1 (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .idex_memread(idex_memread), .idex_rt(idex_rt),
        .branch_taken(branch_taken), .jump(jump), .mem_busy(mem_busy),
        .pc_write(pc_write1), .ifid_hold(ifid_hold1), .ifid_flush(ifid_flush1),
        .idex_bubble(idex_bubble1), .stall_all(stall_all1), .state(state1),
        .stall_count(stall_count1), .flush_count(flush_count1)
    );

    function automatic vec_t mk(logic rst, logic [4:0] rs, logic [4:0] rt, logic uses_rt,
                                logic memread, logic [4:0] ex_rt, logic br, logic jmp,
                                logic busy, logic [4:0] ctl, logic [1:0] st);
        vec_t r;
        r.rst = rst; r.rs = rs; r.rt = rt; r.uses_rt = uses_rt; r.memread = memread;
        r.ex_rt = ex_rt; r.br = br; r.jmp = jmp; r.busy = busy; r.ctl = ctl; r.st = st;
        return r;
    endfunction

    // lu=1 presents a load-use pattern on rs (idex_rt=id_rs=5), else no hazard.
    function automatic vec_t v(logic rst, logic lu, logic br, logic jmp, logic busy,
                               logic [4:0] ctl, logic [1:0] st);
        if (lu) return mk(rst, 5'd5, 5'd2, 1'b1, 1'b1, 5'd5, br, jmp, busy, ctl, st);
        else    return mk(rst, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, br, jmp, busy, ctl, st);
    endfunction

    function automatic logic [4:0] ctl_now();
        return {pc_write, ifid_hold, ifid_flush, idex_bubble, stall_all};
    endfunction

    function automatic logic [4:0] ctl_now1();
        return {pc_write1, ifid_hold1, ifid_flush1, idex_bubble1, stall_all1};
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic drive(vec_t x);
        reset = x.rst; id_rs = x.rs; id_rt = x.rt; id_uses_rt = x.uses_rt;
        idex_memread = x.memread; idex_rt = x.ex_rt; branch_taken = x.br;
        jump = x.jmp; mem_busy = x.busy;
    endtask

    // Drive one vector, record its expectation, compare at the falling edge.
    task automatic apply(int idx, vec_t x);
        exp_t e, got;
        drive(x);
        e.idx = idx; e.ctl = x.ctl; e.st = x.st;
        sb.push_back(e);
        if (!x.rst && !x.ctl[4]) exp_stall++;
        if (!x.rst && x.ctl[2])  exp_flush++;
        @(negedge clock);
        got = sb.pop_front();
        $display("vec %0d: ctl=%b state=%0d (exp ctl=%b state=%0d)",
                 got.idx, ctl_now(), state, got.ctl, got.st);
        check($sformatf("vec%0d_ctl", got.idx), {11'd0, ctl_now()}, {11'd0, got.ctl});
        check($sformatf("vec%0d_state", got.idx), {14'd0, state}, {14'd0, got.st});
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs.push_back(v(1,0,0,0,0,RSTO,0));
        vecs.push_back(v(0,0,0,0,0,NORM,0));
        vecs.push_back(v(0,1,0,0,0,LU,0));     // load-use on rs
        vecs.push_back(v(0,1,0,0,0,NORM,1));   // masked in LDSTALL
        vecs.push_back(v(0,0,0,0,0,NORM,0));
        vecs.push_back(mk(0,5'd0,5'd0,1'b1,1'b1,5'd0,0,0,0,NORM,0)); // idex_rt=0
        vecs.push_back(mk(0,5'd3,5'd7,1'b1,1'b1,5'd7,0,0,0,LU,0));   // via rt
        vecs.push_back(v(0,0,0,0,0,NORM,1));
        vecs.push_back(mk(0,5'd3,5'd7,1'b0,1'b1,5'd7,0,0,0,NORM,0)); // rt unused
        vecs.push_back(v(0,0,1,0,0,FL,0));     // branch pulse
        vecs.push_back(v(0,0,0,0,0,FL,3));
        vecs.push_back(v(0,1,0,0,0,FL,3));     // load-use ignored in FLUSH
        vecs.push_back(v(0,0,0,0,0,NORM,0));
        vecs.push_back(v(0,1,0,1,0,FL,0));     // jump beats load-use
        vecs.push_back(v(0,0,0,0,0,FL,3));
        vecs.push_back(v(0,0,0,0,1,ST,3));     // busy mid-flush
        vecs.push_back(v(0,0,0,0,1,ST,3));
        vecs.push_back(v(0,0,0,0,0,FL,3));
        vecs.push_back(v(0,0,0,0,0,NORM,0));
        vecs.push_back(v(0,1,1,0,1,ST,0));     // busy beats branch and load-use
        vecs.push_back(v(0,1,1,0,1,ST,2));
        vecs.push_back(v(0,1,1,0,1,ST,2));
        vecs.push_back(v(0,1,1,0,1,ST,2));
        vecs.push_back(v(0,1,1,0,0,NORM,2));   // release
        vecs.push_back(v(0,1,1,0,0,FL,0));     // branch then flushed
        vecs.push_back(v(0,0,0,0,0,FL,3));
        vecs.push_back(v(0,0,0,0,0,FL,3));
        vecs.push_back(v(0,0,0,0,0,NORM,0));
        vecs.push_back(v(0,1,0,0,0,LU,0));
        vecs.push_back(v(0,0,1,0,0,FL,1));     // branch from LDSTALL
        vecs.push_back(v(0,0,0,0,0,FL,3));
        vecs.push_back(v(0,0,0,0,0,FL,3));
        vecs.push_back(v(0,0,0,0,0,NORM,0));
        vecs.push_back(v(0,1,0,0,0,LU,0));
        vecs.push_back(v(0,0,0,0,1,ST,1));     // busy from LDSTALL
        vecs.push_back(v(0,0,0,0,0,NORM,2));
        vecs.push_back(v(0,0,0,0,0,NORM,0));
        vecs.push_back(v(0,0,1,0,0,FL,0));
        vecs.push_back(v(1,0,0,0,0,RSTO,3));   // reset aborts FLUSH
        vecs.push_back(v(0,0,0,0,0,NORM,0));
        vecs.push_back(v(0,0,0,0,1,ST,0));
        vecs.push_back(v(1,0,0,0,1,RSTO,2));   // reset aborts MEMWAIT
        vecs.push_back(v(0,0,0,0,0,NORM,0));

        drive(v(1,0,0,0,0,RSTO,0));
        repeat (2) @(posedge clock);
        #1;
        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

`ifdef HAZARD_STATS_EN
        check("stall_count", stall_count, 16'(exp_stall));
        check("flush_count", flush_count, 16'(exp_flush));
`else
        check("stall_count_off", stall_count, 16'd0);
        check("flush_count_off", flush_count, 16'd0);
`endif
        $display("counters: stall=%0d flush=%0d", stall_count, flush_count);

        // FLUSH_CYCLES=1: single flush cycle, no FLUSH state.
        drive(v(1,0,0,0,0,RSTO,0));
        @(negedge clock);
        check("fc1_reset_ctl", {11'd0, ctl_now1()}, {11'd0, RSTO});
        @(posedge clock); #1;
        drive(v(0,0,1,0,0,FL,0));
        @(negedge clock);
        $display("fc1 branch: ctl=%b state=%0d", ctl_now1(), state1);
        check("fc1_branch_ctl", {11'd0, ctl_now1()}, {11'd0, FL});
        check("fc1_branch_state", {14'd0, state1}, 16'd0);
        @(posedge clock); #1;
        drive(v(0,0,0,0,0,NORM,0));
        @(negedge clock);
        $display("fc1 after: ctl=%b state=%0d", ctl_now1(), state1);
        check("fc1_after_ctl", {11'd0, ctl_now1()}, {11'd0, NORM});
        check("fc1_after_state", {14'd0, state1}, 16'd0);
        @(posedge clock); #1;

`ifdef HAZARD_STATS_EN
        // Long memory wait drives the stall counter into saturation.
        drive(v(0,0,0,0,1,ST,0));
        repeat (65540) @(posedge clock);
        #1;
        drive(v(0,0,0,0,0,NORM,0));
        @(negedge clock);
        $display("saturation: stall=%h", stall_count);
        check("stall_sat", stall_count, 16'hFFFF);
        check("sat_state", {14'd0, state}, 16'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
